// File: rtl/ring_counter_pkg.sv
// Shared encodings and helpers for the multimode ring counter and its state checker.
package ring_counter_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Seed pattern: MSB of a width-bit word set, all other bits clear (width <= 32).
  function automatic logic [31:0] seed(input int unsigned width);
    return 32'h1 << (width - 1);
  endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check of a ring/Johnson counter pattern for the selected mode.
module ring_state_check
  import ring_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH-2:0] ONE_E = (WIDTH-1)'(1);

  // One bit per adjacent pair that differs; Johnson states have at most one.
  logic [WIDTH-2:0] edges;
  assign edges = count[WIDTH-1:1] ^ count[WIDTH-2:0];

  always_comb begin
    illegal = 1'b0;
    if (mode == MODE_JOHNSON) begin
      illegal = (edges & (edges - ONE_E)) != '0;
    end else begin
      illegal = (count == '0) || ((count & (count - ONE_W)) != '0);
    end
  end

endmodule

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson counter with direction, load, step position, wrap pulse and
// illegal-state detection with optional self-correction.
module multimode_ring_counter
  import ring_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          AUTOCORRECT = 1'b1,
  localparam int unsigned PW         = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             illegal,
  output logic             err_sticky
);

  localparam logic [31:0]       SEED_WORD = seed(WIDTH);
  localparam logic [WIDTH-1:0]  SEED      = SEED_WORD[WIDTH-1:0];
  localparam logic [PW-1:0]     RING_LAST = PW'(WIDTH - 1);
  localparam logic [PW-1:0]     JOHN_LAST = PW'(2 * WIDTH - 1);
  localparam logic [PW-1:0]     POS_ONE   = PW'(1);

  logic [WIDTH-1:0] count_q, count_d, step;
  logic [PW-1:0]    pos_q, pos_d, pos_step, pos_last;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             fill_r, fill_l;

  ring_state_check #(
    .WIDTH (WIDTH)
  ) u_check (
    .count   (count_q),
    .mode    (mode),
    .illegal (illegal)
  );

  // Raw one-step rotation and modulo-P position update.
  always_comb begin
    fill_r = count_q[0];
    fill_l = count_q[WIDTH-1];
    if (mode == MODE_JOHNSON) begin
      fill_r = ~count_q[0];
      fill_l = ~count_q[WIDTH-1];
    end
    if (dir == DIR_LEFT) begin
      step = {count_q[WIDTH-2:0], fill_l};
    end else begin
      step = {fill_r, count_q[WIDTH-1:1]};
    end

    pos_last = (mode == MODE_JOHNSON) ? JOHN_LAST : RING_LAST;
    if (dir == DIR_LEFT) begin
      pos_step = (pos_q == '0) ? pos_last : pos_q - POS_ONE;
    end else begin
      pos_step = (pos_q == pos_last) ? '0 : pos_q + POS_ONE;
    end
  end

  always_comb begin
    count_d = count_q;
    pos_d   = pos_q;
    wrap_d  = 1'b0;
    err_d   = err_q | illegal;
    if (init) begin
      count_d = SEED;
      pos_d   = '0;
      err_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
      pos_d   = '0;
    end else if (en) begin
      if (illegal && AUTOCORRECT) begin
        // A correction returns to SEED but is deliberately not reported as a wrap.
        count_d = SEED;
        pos_d   = '0;
      end else begin
        count_d = step;
        pos_d   = pos_step;
        wrap_d  = (step == SEED);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= SEED;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pos_q   <= pos_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count      = count_q;
  assign pos        = pos_q;
  assign wrap       = wrap_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Self-checking bench: three counter instances (W8 corrected, W8 raw, W5 corrected)
// driven in lockstep and compared to a sequence-index reference model.
module tb_multimode_ring_counter;

  logic       clk = 1'b0;
  logic       rst_n, init, load, en, mode, dir;
  logic [7:0] load_val;

  logic [7:0] count_a, count_b;
  logic [4:0] count_c;
  logic [3:0] pos_a, pos_b, pos_c;
  logic       wrap_a, wrap_b, wrap_c, ill_a, ill_b, ill_c, err_a, err_b, err_c;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multimode_ring_counter #(.WIDTH(8), .AUTOCORRECT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .init(init), .load(load), .load_val(load_val), .en(en),
    .mode(mode), .dir(dir), .count(count_a), .pos(pos_a), .wrap(wrap_a),
    .illegal(ill_a), .err_sticky(err_a)
  );

  multimode_ring_counter #(.WIDTH(8), .AUTOCORRECT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .init(init), .load(load), .load_val(load_val), .en(en),
    .mode(mode), .dir(dir), .count(count_b), .pos(pos_b), .wrap(wrap_b),
    .illegal(ill_b), .err_sticky(err_b)
  );

  multimode_ring_counter #(.WIDTH(5), .AUTOCORRECT(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .init(init), .load(load), .load_val(load_val[4:0]), .en(en),
    .mode(mode), .dir(dir), .count(count_c), .pos(pos_c), .wrap(wrap_c),
    .illegal(ill_c), .err_sticky(err_c)
  );

  logic [31:0] o_count[3];
  int          o_pos[3];
  logic        o_wrap[3], o_ill[3], o_err[3];

  always_comb begin
    o_count[0] = 32'(count_a); o_count[1] = 32'(count_b); o_count[2] = 32'(count_c);
    o_pos[0] = int'(pos_a); o_pos[1] = int'(pos_b); o_pos[2] = int'(pos_c);
    o_wrap[0] = wrap_a; o_wrap[1] = wrap_b; o_wrap[2] = wrap_c;
    o_ill[0] = ill_a; o_ill[1] = ill_b; o_ill[2] = ill_c;
    o_err[0] = err_a; o_err[1] = err_b; o_err[2] = err_c;
  end

  // Reference model: a legal state is its index k in the mode's sequence.
  int W[3] = '{8, 8, 5};
  bit AC[3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] m_count[3];
  int          m_pos[3];
  bit          m_wrap[3], m_err[3];
  bit          m_mode;

  function automatic logic [31:0] mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] sd(input int w);
    return 32'h1 << (w - 1);
  endfunction

  // k-th pattern after SEED stepping right: ring walks a single 1 down from the MSB;
  // Johnson fills ones from the MSB down, then drains them from the MSB.
  function automatic logic [31:0] pat(input bit md, input int w, input int k);
    if (!md) return 32'h1 << (w - 1 - k);
    if (k < w) return mask(w) & ~mask(w - 1 - k);
    return mask(2 * w - 1 - k);
  endfunction

  function automatic int idx(input bit md, input int w, input logic [31:0] c);
    int p;
    p = md ? 2 * w : w;
    for (int k = 0; k < p; k++) if (pat(md, w, k) == c) return k;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_count[i] = sd(W[i]);
      m_pos[i] = 0;
      m_wrap[i] = 1'b0;
      m_err[i] = 1'b0;
    end
    m_mode = 1'b0;
  endtask

  // Drive one clock's worth of controls, advance the model, sample #1 after the edge.
  task automatic cycle(input bit i_init, input bit i_load, input logic [31:0] lv,
                       input bit i_en, input bit md, input bit dr);
    logic [31:0] nc[3];
    int np[3];
    bit nw[3], ne[3];
    logic [31:0] c;
    int p, k, w;
    init = i_init; load = i_load; load_val = lv[7:0]; en = i_en; mode = md; dir = dr;
    for (int i = 0; i < 3; i++) begin
      w = W[i];
      p = md ? 2 * w : w;
      c = m_count[i];
      k = idx(md, w, c);
      nc[i] = c; np[i] = m_pos[i]; nw[i] = 1'b0; ne[i] = m_err[i] | (k < 0);
      if (i_init) begin
        nc[i] = sd(w); np[i] = 0; ne[i] = 1'b0;
      end else if (i_load) begin
        nc[i] = lv & mask(w); np[i] = 0;
      end else if (i_en) begin
        np[i] = dr ? (m_pos[i] + p - 1) % p : (m_pos[i] + 1) % p;
        if (k < 0 && AC[i]) begin
          nc[i] = sd(w); np[i] = 0;
        end else begin
          if (k >= 0) nc[i] = pat(md, w, dr ? (k + p - 1) % p : (k + 1) % p);
          else if (dr) nc[i] = ((c << 1) & mask(w)) | 32'(md ^ c[w-1]);
          else nc[i] = (c >> 1) | (32'(md ^ c[0]) << (w - 1));
          nw[i] = (nc[i] == sd(w));
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m_count[i] = nc[i]; m_pos[i] = np[i]; m_wrap[i] = nw[i]; m_err[i] = ne[i];
    end
    m_mode = md;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (count_a !== 8'h80) begin n_fail++; $display("FAIL reset count: got %h want 80", count_a); end
    n_cmp++; if (pos_a !== 4'd0) begin n_fail++; $display("FAIL reset pos: got %0d want 0", pos_a); end
    n_cmp++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL reset wrap: got %b want 0", wrap_a); end
    n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", err_a); end
    n_cmp++; if (ill_a !== 1'b0) begin n_fail++; $display("FAIL reset illegal: got %b want 0", ill_a); end
    n_cmp++; if (count_c !== 5'h10) begin n_fail++; $display("FAIL reset count w5: got %h want 10", count_c); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ring_right();
    logic [7:0] exp [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 1, 0, 0);
      n_cmp++; if (count_a !== exp[i]) begin n_fail++; $display("FAIL ring_right count %0d: got %h want %h", i, count_a, exp[i]); end
      n_cmp++; if (pos_a !== 4'((i + 1) % 8)) begin n_fail++; $display("FAIL ring_right pos %0d: got %0d want %0d", i, pos_a, (i + 1) % 8); end
      n_cmp++; if (wrap_a !== (i == 7)) begin n_fail++; $display("FAIL ring_right wrap %0d: got %b want %b", i, wrap_a, i == 7); end
      n_cmp++; if (ill_a !== 1'b0) begin n_fail++; $display("FAIL ring_right illegal %0d: got %b want 0", i, ill_a); end
    end
  endtask

  task automatic test_johnson_right();
    logic [7:0] exp [16] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h7F,
                             8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 0, 1, 1, 0);
      n_cmp++; if (count_a !== exp[i]) begin n_fail++; $display("FAIL johnson count %0d: got %h want %h", i, count_a, exp[i]); end
      n_cmp++; if (wrap_a !== (i == 15)) begin n_fail++; $display("FAIL johnson wrap %0d: got %b want %b", i, wrap_a, i == 15); end
      n_cmp++; if (ill_a !== 1'b0) begin n_fail++; $display("FAIL johnson illegal %0d: got %b want 0", i, ill_a); end
    end
    cycle(0, 0, 0, 1, 1, 1);
    n_cmp++; if (count_a !== 8'h00 || pos_a !== 4'd15) begin n_fail++; $display("FAIL johnson_left count/pos: got %h/%0d want 00/15", count_a, pos_a); end
  endtask

  task automatic test_ring_left();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 1);
    n_cmp++; if (count_a !== 8'h01 || pos_a !== 4'd7) begin n_fail++; $display("FAIL ring_left step1: got %h/%0d want 01/7", count_a, pos_a); end
    cycle(0, 0, 0, 1, 0, 1);
    n_cmp++; if (count_a !== 8'h02 || pos_a !== 4'd6) begin n_fail++; $display("FAIL ring_left step2: got %h/%0d want 02/6", count_a, pos_a); end
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (count_a !== 8'h01 || pos_a !== 4'd7) begin n_fail++; $display("FAIL ring_reverse: got %h/%0d want 01/7", count_a, pos_a); end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 32'h55, 0, 0, 0);
      n_cmp++; if (count_a !== 8'h01 || pos_a !== 4'd7 || wrap_a !== 1'b0) begin n_fail++; $display("FAIL hold %0d: got %h/%0d/%b want 01/7/0", i, count_a, pos_a, wrap_a); end
    end
    cycle(1, 1, 32'h10, 1, 0, 0);
    n_cmp++; if (count_a !== 8'h80 || pos_a !== 4'd0) begin n_fail++; $display("FAIL init_priority: got %h/%0d want 80/0", count_a, pos_a); end
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 1, 32'h10, 1, 0, 0);
    n_cmp++; if (count_a !== 8'h10 || pos_a !== 4'd0 || wrap_a !== 1'b0) begin n_fail++; $display("FAIL load_priority: got %h/%0d/%b want 10/0/0", count_a, pos_a, wrap_a); end
  endtask

  task automatic test_illegal();
    cycle(0, 1, 32'h81, 0, 0, 0);
    n_cmp++; if (ill_a !== 1'b1 || ill_b !== 1'b1) begin n_fail++; $display("FAIL illegal_flag: got %b%b want 11", ill_a, ill_b); end
    n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", err_a); end
    cycle(0, 0, 0, 0, 0, 0);
    n_cmp++; if (err_a !== 1'b1 || err_b !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b%b want 11", err_a, err_b); end
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (count_a !== 8'h80 || pos_a !== 4'd0 || wrap_a !== 1'b0) begin n_fail++; $display("FAIL autocorrect: got %h/%0d/%b want 80/0/0", count_a, pos_a, wrap_a); end
    n_cmp++; if (count_b !== 8'hC0 || pos_b !== 4'd1) begin n_fail++; $display("FAIL raw_rotate: got %h/%0d want c0/1", count_b, pos_b); end
    cycle(0, 1, 32'h04, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL err_sticky_hold: got %b want 1", err_a); end
    cycle(1, 0, 0, 0, 0, 0);
    n_cmp++; if (err_a !== 1'b0 || err_b !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b%b want 00", err_a, err_b); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
    n_cmp++; if (count_a !== 8'h08) begin n_fail++; $display("FAIL pre_reset count: got %h want 08", count_a); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (count_a !== 8'h80 || pos_a !== 4'd0) begin n_fail++; $display("FAIL async_reset: got %h/%0d want 80/0", count_a, pos_a); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_w5_johnson();
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 1, 1, 0);
      n_cmp++; if (wrap_c !== (i == 9)) begin n_fail++; $display("FAIL w5_wrap %0d: got %b want %b", i, wrap_c, i == 9); end
    end
    n_cmp++; if (count_c !== 5'h10 || pos_c !== 4'd0) begin n_fail++; $display("FAIL w5_end: got %h/%0d want 10/0", count_c, pos_c); end
  endtask

  task automatic test_random();
    bit ri, rl, re, rd, md;
    logic [31:0] lv;
    md = m_mode;
    for (int n = 0; n < 400; n++) begin
      ri = ($urandom_range(15) == 0);
      if (ri) md = 1'($urandom_range(1));
      rl = ($urandom_range(7) == 0);
      re = ($urandom_range(3) != 0);
      rd = 1'($urandom_range(1));
      lv = ($urandom_range(1) == 1) ? pat(md, 8, int'($urandom_range(md ? 15 : 7)))
                                    : 32'($urandom_range(255));
      cycle(ri, rl, lv, re, md, rd);
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (o_count[i] !== m_count[i]) begin n_fail++; $display("FAIL rnd count dut%0d cyc%0d: got %h want %h", i, n, o_count[i], m_count[i]); end
        n_cmp++; if (o_pos[i] !== m_pos[i]) begin n_fail++; $display("FAIL rnd pos dut%0d cyc%0d: got %0d want %0d", i, n, o_pos[i], m_pos[i]); end
        n_cmp++; if (o_wrap[i] !== m_wrap[i]) begin n_fail++; $display("FAIL rnd wrap dut%0d cyc%0d: got %b want %b", i, n, o_wrap[i], m_wrap[i]); end
        n_cmp++; if (o_err[i] !== m_err[i]) begin n_fail++; $display("FAIL rnd err dut%0d cyc%0d: got %b want %b", i, n, o_err[i], m_err[i]); end
        n_cmp++; if (o_ill[i] !== (idx(md, W[i], m_count[i]) < 0)) begin n_fail++; $display("FAIL rnd illegal dut%0d cyc%0d: got %b want %b", i, n, o_ill[i], idx(md, W[i], m_count[i]) < 0); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; init = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; mode = 1'b0; dir = 1'b0;
    test_reset();
    test_ring_right();
    test_johnson_right();
    test_ring_left();
    test_priority();
    test_illegal();
    test_async_reset();
    test_w5_johnson();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
